cve2_rf_wb_arbiter: RTL

//  Shares the single register-file write port between the EX-stage result and asynchronous LSU load returns.

---
 rtl/cve2_rf_wb_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cve2_rf_wb_arbiter.sv
// ============================================================================
// Module   : cve2_rf_wb_arbiter
// Brief    : Register-file write-port arbiter between EX results and LSU load
//            returns, with a one-load scoreboard and a one-entry EX hold buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cve2_rf_wb_arbiter #(
    parameter int unsigned DataWidth         = 32,
    parameter bit          DummyInstructions = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ex_we_i,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    input  logic                 ex_dummy_i,
    output logic                 ex_ready_o,
    input  logic                 lsu_issue_i,
    input  logic [4:0]           lsu_issue_rd_i,
    input  logic                 lsu_rvalid_i,
    input  logic [DataWidth-1:0] lsu_rdata_i,
    input  logic                 lsu_err_i,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 stall_id_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 proto_err_o
);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [4:0]             pend_rd_q, pend_rd_d;
    logic                   hold_valid_q, hold_valid_d;
    logic [4:0]             hold_addr_q, hold_addr_d;
    logic [DataWidth-1:0]   hold_data_q, hold_data_d;

    logic load_ret;
    logic pend_live;
    logic waw;
    logic ex_acc;
    logic ex_addr_ok;
    logic stall_a;
    logic stall_b;

    // A load return owns the port for the whole cycle, even if it writes nothing.
    assign load_ret   = (state_q == WAIT_LOAD) & lsu_rvalid_i;
    assign pend_live  = (state_q == WAIT_LOAD) & ~lsu_rvalid_i;
    assign waw        = pend_live & (ex_waddr_i == pend_rd_q) & (pend_rd_q != 5'd0);
    assign ex_ready_o = ~hold_valid_q & ~waw;
    assign ex_acc     = ex_we_i & ex_ready_o;
    assign ex_addr_ok = (ex_waddr_i != 5'd0) | (DummyInstructions & ex_dummy_i);

    assign proto_err_o = ((state_q == IDLE) & lsu_rvalid_i) |
                         ((state_q == WAIT_LOAD) & lsu_issue_i & ~lsu_rvalid_i);

    assign stall_a = (raddr_a_i != 5'd0) &
                     ((pend_live & (raddr_a_i == pend_rd_q)) |
                      (hold_valid_q & (raddr_a_i == hold_addr_q)));
    assign stall_b = (raddr_b_i != 5'd0) &
                     ((pend_live & (raddr_b_i == pend_rd_q)) |
                      (hold_valid_q & (raddr_b_i == hold_addr_q)));
    assign stall_id_o = stall_a | stall_b;

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = 5'd0;
        rf_wdata_o = '0;
        if (load_ret) begin
            rf_we_o    = ~lsu_err_i & (pend_rd_q != 5'd0);
            rf_waddr_o = pend_rd_q;
            rf_wdata_o = lsu_rdata_i;
        end else if (hold_valid_q) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = hold_addr_q;
            rf_wdata_o = hold_data_q;
        end else if (ex_acc) begin
            rf_we_o    = ex_addr_ok;
            rf_waddr_o = ex_waddr_i;
            rf_wdata_o = ex_wdata_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_rd_d    = pend_rd_q;
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;

        case (state_q)
            IDLE: begin
                if (lsu_issue_i) begin
                    state_d   = WAIT_LOAD;
                    pend_rd_d = lsu_issue_rd_i;
                end
            end
            WAIT_LOAD: begin
                // Back-to-back load: the return and the new issue share one cycle.
                if (lsu_rvalid_i) begin
                    if (lsu_issue_i) begin
                        pend_rd_d = lsu_issue_rd_i;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_ret & ex_acc & ex_addr_ok) begin
            hold_valid_d = 1'b1;
            hold_addr_d  = ex_waddr_i;
            hold_data_d  = ex_wdata_i;
        end else if (hold_valid_q & ~load_ret) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            pend_rd_q    <= 5'd0;
            hold_valid_q <= 1'b0;
            hold_addr_q  <= 5'd0;
            hold_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            pend_rd_q    <= pend_rd_d;
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
        end
    end

endmodule

`default_nettype wire
